// File: rtl/cv32e40p_instr_obi_adapter.sv
// cv32e40p_instr_obi_adapter
// Bridges the prefetch controller's trans_valid/ready/addr handshake onto an
// OBI instruction-fetch A channel and forwards R-channel responses unchanged.
// Once req is raised without a grant, the address is captured and replayed
// until granted, which keeps req/addr stable on the bus. Outstanding
// granted-but-unanswered transactions are bounded by MAX_OUTSTANDING.
// Optional macro: CV32E40P_INSTR_OBI_ERR_STICKY_EN adds a sticky bus-error flag.
module cv32e40p_instr_obi_adapter #(
  parameter int unsigned  MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  // Upstream transaction interface (prefetch controller)
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [31:0]      trans_addr_i,
  // OBI A channel
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [31:0]      obi_addr_o,
  // OBI R channel
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  input  logic             obi_err_i,
  // Response toward prefetch controller / fetch FIFO
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  // Status
  output logic [CNT_W-1:0] outstanding_o,
  input  logic             err_clear_i,
  output logic             err_sticky_o
);

  typedef enum logic {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             room;
  logic             cnt_inc;
  logic             cnt_dec;

  // Only registered count feeds room, so rvalid never reaches req/ready combinationally.
  assign room = (cnt_q < MAX_CNT);

  // A-channel and upstream handshake: pass-through when idle, replay captured address when held.
  always_comb begin
    obi_req_o     = trans_valid_i && room;
    obi_addr_o    = trans_addr_i;
    trans_ready_o = room;
    if (state_q == REGISTERED) begin
      obi_req_o     = 1'b1;
      obi_addr_o    = addr_q;
      trans_ready_o = 1'b0;
    end
  end

  // Capture the address of an ungranted request and hold it until the grant arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRANSPARENT;
      addr_q  <= '0;
    end else begin
      case (state_q)
        TRANSPARENT: begin
          if (obi_req_o && !obi_gnt_i) begin
            addr_q  <= trans_addr_i;
            state_q <= REGISTERED;
          end
        end
        REGISTERED: begin
          if (obi_gnt_i) begin
            state_q <= TRANSPARENT;
          end
        end
        default: state_q <= TRANSPARENT;
      endcase
    end
  end

  // A response arriving with nothing outstanding is ignored so the count never wraps.
  assign cnt_inc = obi_req_o && obi_gnt_i;
  assign cnt_dec = obi_rvalid_i && (cnt_q != '0);

  // Next outstanding count: grant adds one, response removes one, both cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

  // Responses are forwarded with zero latency; the consumer is always ready.
  assign resp_valid_o = obi_rvalid_i;
  assign resp_rdata_o = obi_rdata_i;
  assign resp_err_o   = obi_rvalid_i && obi_err_i;

`ifdef CV32E40P_INSTR_OBI_ERR_STICKY_EN
  logic err_sticky_q;

  // Sticky error: a new error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (obi_rvalid_i && obi_err_i) begin
      err_sticky_q <= 1'b1;
    end else if (err_clear_i) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign err_sticky_o = err_sticky_q;
`else
  logic unused_err_clear;

  assign unused_err_clear = err_clear_i;
  assign err_sticky_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_adapter.sv
// Testbench for cv32e40p_instr_obi_adapter: directed scenarios followed by
// random traffic, checked per cycle against a transaction-level model and by
// scoreboards for A-channel addresses and R-channel responses.
module tb_cv32e40p_instr_obi_adapter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trans_valid = 1'b0;
  logic        trans_ready;
  logic [31:0] trans_addr = '0;
  logic        obi_req;
  logic        obi_gnt = 1'b0;
  logic [31:0] obi_addr;
  logic        obi_rvalid = 1'b0;
  logic [31:0] obi_rdata = '0;
  logic        obi_err = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  outstanding;
  logic        err_clear = 1'b0;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;

  // Reference model: a pending (ungranted, already accepted) request list of
  // depth at most one, an outstanding integer count and a sticky error bit.
  logic [31:0] m_held[$];
  int          m_cnt = 0;
  bit          m_sticky = 1'b0;

  // Scoreboards
  logic [31:0] exp_a_q[$];
  logic [32:0] exp_r_q[$];

  cv32e40p_instr_obi_adapter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trans_valid_i (trans_valid),
    .trans_ready_o (trans_ready),
    .trans_addr_i  (trans_addr),
    .obi_req_o     (obi_req),
    .obi_gnt_i     (obi_gnt),
    .obi_addr_o    (obi_addr),
    .obi_rvalid_i  (obi_rvalid),
    .obi_rdata_i   (obi_rdata),
    .obi_err_i     (obi_err),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_err_o    (resp_err),
    .outstanding_o (outstanding),
    .err_clear_i   (err_clear),
    .err_sticky_o  (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle reference check and model update (inputs are stable at negedge).
  always @(negedge clk) begin
    logic        e_req;
    logic        e_ready;
    logic [31:0] e_addr;
    logic        granted;
    if (!rst_n) begin
      m_held.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
      exp_a_q.delete();
    end
    e_ready = (m_held.size() == 0) && (m_cnt < MAX);
    e_req   = (m_held.size() != 0) ? 1'b1 : (trans_valid && (m_cnt < MAX));
    e_addr  = (m_held.size() != 0) ? m_held[0] : trans_addr;
    chk("req", 32'(obi_req), 32'(e_req));
    chk("ready", 32'(trans_ready), 32'(e_ready));
    chk("cnt", 32'(outstanding), 32'(m_cnt));
    if (e_req) chk("addr", obi_addr, e_addr);
    chk("resp_valid", 32'(resp_valid), 32'(obi_rvalid));
    chk("resp_err", 32'(resp_err), 32'(obi_rvalid && obi_err));
    chk("sticky", 32'(err_sticky), 32'(m_sticky));
    if (rst_n) begin
      if (e_ready && trans_valid) exp_a_q.push_back(trans_addr);
      granted = e_req && obi_gnt;
      if (m_held.size() != 0) begin
        if (obi_gnt) m_held.delete();
      end else if (e_req && !obi_gnt) begin
        m_held.push_back(trans_addr);
      end
      if (granted && !obi_rvalid) m_cnt++;
      else if (obi_rvalid && !granted && m_cnt > 0) m_cnt--;
`ifdef CV32E40P_INSTR_OBI_ERR_STICKY_EN
      if (obi_rvalid && obi_err) m_sticky = 1'b1;
      else if (err_clear) m_sticky = 1'b0;
`endif
    end
  end

  // Monitor: pops scoreboards whenever the DUT presents a grant or a response.
  always begin
    logic [31:0] a;
    logic [32:0] r;
    @(negedge clk);
    #1;
    if (rst_n && obi_req && obi_gnt) begin
      if (exp_a_q.size() == 0) begin
        total++; bad++;
        $display("FAIL a_sb unexpected grant addr=%h required=none", obi_addr);
      end else begin
        a = exp_a_q.pop_front();
        chk("a_sb_addr", obi_addr, a);
      end
    end
    if (resp_valid) begin
      if (exp_r_q.size() == 0) begin
        total++; bad++;
        $display("FAIL r_sb unexpected resp data=%h required=none", resp_rdata);
      end else begin
        r = exp_r_q.pop_front();
        chk("r_sb_data", resp_rdata, r[32:1]);
        chk("r_sb_err", 32'(resp_err), 32'(r[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit tv, input logic [31:0] a, input bit g, input bit rv,
                       input logic [31:0] d, input bit e, input bit clr);
    trans_valid = tv;
    trans_addr  = a;
    obi_gnt     = g;
    obi_rvalid  = rv;
    obi_rdata   = d;
    obi_err     = e;
    err_clear   = clr;
    if (rv) exp_r_q.push_back({d, e});
    $display("cycle t=%0t tv=%0b addr=%h gnt=%0b rv=%0b rdata=%h err=%0b clr=%0b",
             $time, tv, a, g, rv, d, e, clr);
  endtask

  task automatic cyc(input bit tv, input logic [31:0] a, input bit g, input bit rv,
                     input logic [31:0] d, input bit e, input bit clr);
    step();
    apply(tv, a, g, rv, d, e, clr);
  endtask

  task automatic idle();
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    // Reset
    idle(); idle();
    step(); rst_n = 1'b1;
    idle();

    // 1: transparent request granted in the same cycle
    cyc(1, 32'h0000_0100, 1, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 1, 32'h1111_1111, 0, 0);

    // 2: held request, upstream address changes while waiting
    cyc(1, 32'h0000_0200, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0300, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0300, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0300, 1, 0, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 1, 32'h2222_2222, 0, 0);

    // 3: outstanding limit blocks requests until a response returns
    cyc(1, 32'h0000_0400, 1, 0, 0, 0, 0);
    cyc(1, 32'h0000_0404, 1, 0, 0, 0, 0);
    cyc(1, 32'h0000_0408, 1, 0, 0, 0, 0);
    cyc(1, 32'h0000_0408, 0, 1, 32'hDEAD_BEEF, 0, 0);
    cyc(1, 32'h0000_0408, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h3333_3333, 0, 0);
    cyc(0, 0, 0, 1, 32'h4444_4444, 0, 0);

    // 4: grant and response together; response with nothing outstanding
    cyc(1, 32'h0000_0500, 1, 0, 0, 0, 0);
    cyc(1, 32'h0000_0504, 1, 1, 32'h5555_5555, 0, 0);
    cyc(0, 0, 0, 1, 32'h6666_6666, 0, 0);
    cyc(0, 0, 0, 1, 32'h7777_7777, 0, 0);
    idle();

    // 5: error response, sticky flag, clear, error-over-clear priority
    cyc(0, 0, 0, 1, 32'h8888_8888, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle();
    cyc(0, 0, 0, 1, 32'h9999_9999, 1, 1);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle();

    // 6: reset while a request is held
    cyc(1, 32'h0000_0600, 1, 0, 0, 0, 0);
    cyc(1, 32'h0000_0604, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("async_req_drop", 32'(obi_req), 32'h0);
    chk("async_cnt_clear", 32'(outstanding), 32'h0);
    idle();
    step(); rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_0700, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hAAAA_AAAA, 0, 0);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step();
      apply(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 2) == 1,
            (m_cnt > 0) && (($urandom % 3) == 0), $urandom, ($urandom % 8) == 0,
            ($urandom % 8) == 0);
    end

    // Drain: grant anything held, then answer everything outstanding
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      apply(0, 0, 0, m_cnt > 0, $urandom, 0, 0);
    end
    idle();
    idle();
    chk("a_sb_empty", 32'(exp_a_q.size()), 32'h0);
    chk("r_sb_empty", 32'(exp_r_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
